// File: rtl/interrupt_controller.sv
// Interrupt requester for the multi-cycle CPU: edge-detects device and NMI lines, latches them
// as pending, and runs the request/accept/service handshake with the control unit.
module interrupt_controller #(
    parameter int               N_SRC    = 4,
    parameter int               IDW      = 2,
    parameter logic [N_SRC-1:0] MASK_RST = {N_SRC{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             nmi_src,
    input  logic             mask_wr,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             int_ack,
    input  logic             ack_is_mi,
    input  logic             eoi,
    output logic             interrupt,
    output logic             nmint,
    output logic             busy,
    output logic [IDW-1:0]   irq_id,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] mask,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE,
        REQ_MI,
        REQ_NMI,
        SVC_MI,
        SVC_NMI
    } state_t;

    state_t           state_q, state_d;
    logic [N_SRC-1:0] src_q;
    logic             nmi_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic             nmi_pend_q, nmi_pend_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [IDW-1:0]   irq_id_q, irq_id_d;
    logic             err_q, err_d;

    logic [N_SRC-1:0] edge_mi;
    logic             edge_nmi;
    logic [N_SRC-1:0] eligible;
    logic [IDW-1:0]   sel_id;
    logic             in_svc;
    logic             ack_ok;
    logic             proto_err;
    logic [N_SRC-1:0] clr_mi;
    logic             clr_nmi;

    // Lowest-index eligible source wins; scanning downward leaves the lowest one in sel_id.
    always_comb begin
        sel_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_id = IDW'(i);
            end
        end
    end

    // NOTE: every signal written in this block gets a default first, so no path can infer a latch.
    always_comb begin
        edge_mi   = irq_src & ~src_q;
        edge_nmi  = nmi_src & ~nmi_q;
        eligible  = pending_q & mask_q;
        mask_d    = mask_wr ? mask_wdata : mask_q;
        in_svc    = (state_q == SVC_MI) || (state_q == SVC_NMI);
        ack_ok    = ((state_q == REQ_MI) && ack_is_mi) || ((state_q == REQ_NMI) && !ack_is_mi);
        proto_err = (int_ack && !ack_ok) || (eoi && !in_svc);

        state_d  = state_q;
        irq_id_d = irq_id_q;
        clr_mi   = '0;
        clr_nmi  = 1'b0;

        // A protocol violation freezes the handshake for that cycle and only raises err.
        if (!proto_err) begin
            unique case (state_q)
                IDLE: begin
                    if (nmi_pend_q) begin
                        state_d = REQ_NMI;
                    end else if (|eligible) begin
                        state_d  = REQ_MI;
                        irq_id_d = sel_id;
                    end
                end
                REQ_MI: begin
                    if (int_ack) begin
                        state_d          = SVC_MI;
                        clr_mi[irq_id_q] = 1'b1;
                    end else if (nmi_pend_q) begin
                        state_d = REQ_NMI;
                    end else if (!mask_d[irq_id_q]) begin
                        state_d = IDLE;
                    end
                end
                REQ_NMI: begin
                    if (int_ack) begin
                        state_d = SVC_NMI;
                        clr_nmi = 1'b1;
                    end
                end
                SVC_MI, SVC_NMI: begin
                    if (eoi) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A new edge beats a same-cycle acknowledge of the same bit.
        pending_d  = (pending_q & ~clr_mi) | edge_mi;
        nmi_pend_d = (nmi_pend_q & ~clr_nmi) | edge_nmi;
        err_d      = err_q | proto_err;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        src_q <= irq_src;
        nmi_q <= nmi_src;
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            nmi_pend_q <= 1'b0;
            mask_q     <= MASK_RST;
            irq_id_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            nmi_pend_q <= nmi_pend_d;
            mask_q     <= mask_d;
            irq_id_q   <= irq_id_d;
            err_q      <= err_d;
        end
    end

    assign interrupt = (state_q == REQ_MI);
    assign nmint     = (state_q == REQ_NMI);
    assign busy      = (state_q == SVC_MI) || (state_q == SVC_NMI);
    assign irq_id    = irq_id_q;
    assign pending   = pending_q;
    assign mask      = mask_q;
    assign err       = err_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: directed scenarios plus random traffic, every cycle
// checked against a behavioural model of the request/service handshake.
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] irq_src = '0;
    logic       nmi_src = 1'b0;
    logic       mask_wr = 1'b0;
    logic [3:0] mask_wdata = '0;
    logic       int_ack = 1'b0;
    logic       ack_is_mi = 1'b0;
    logic       eoi = 1'b0;
    logic       interrupt, nmint, busy, err;
    logic [1:0] irq_id;
    logic [3:0] pending, mask;

    interrupt_controller #(.N_SRC(4), .IDW(2), .MASK_RST(4'b1111)) dut (
        .clk(clk), .rst(rst), .irq_src(irq_src), .nmi_src(nmi_src),
        .mask_wr(mask_wr), .mask_wdata(mask_wdata), .int_ack(int_ack),
        .ack_is_mi(ack_is_mi), .eoi(eoi), .interrupt(interrupt), .nmint(nmint),
        .busy(busy), .irq_id(irq_id), .pending(pending), .mask(mask), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       intr;
        logic       nmint;
        logic       busy;
        logic [1:0] id;
        logic [3:0] pend;
        logic [3:0] mask;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: what is being asked for, what is being served, and the latched bits.
    bit   m_req_mi, m_req_nmi;
    int   m_serving;        // 0 nothing, 1 maskable handler, 2 NMI handler
    int   m_id;
    bit   m_pend[4];
    bit   m_npend;
    bit   m_mask[4];
    bit   m_err;
    bit   m_prev_src[4];
    bit   m_prev_nmi;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] pack4(input bit v[4]);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = v[i];
        return r;
    endfunction

    task automatic model_step();
        bit e[4];
        bit en;
        bit err_now;
        bit new_mask[4];
        bit found;
        int clr;
        if (rst) begin
            m_req_mi = 0; m_req_nmi = 0; m_serving = 0; m_id = 0;
            m_npend = 0; m_err = 0;
            for (int i = 0; i < 4; i++) begin
                m_pend[i] = 0; m_mask[i] = 1; m_prev_src[i] = irq_src[i];
            end
            m_prev_nmi = nmi_src;
            return;
        end
        for (int i = 0; i < 4; i++) begin
            e[i]        = irq_src[i] && !m_prev_src[i];
            new_mask[i] = mask_wr ? mask_wdata[i] : m_mask[i];
        end
        en      = nmi_src && !m_prev_nmi;
        clr     = -1;
        err_now = (int_ack && !((m_req_mi && ack_is_mi) || (m_req_nmi && !ack_is_mi)))
               || (eoi && m_serving == 0);
        if (!err_now) begin
            if (m_serving != 0) begin
                if (eoi) m_serving = 0;
            end else if (m_req_nmi) begin
                if (int_ack) begin
                    m_req_nmi = 0; m_serving = 2; m_npend = 0;
                end
            end else if (m_req_mi) begin
                if (int_ack) begin
                    m_req_mi = 0; m_serving = 1; clr = m_id;
                end else if (m_npend) begin
                    m_req_mi = 0; m_req_nmi = 1;
                end else if (!new_mask[m_id]) begin
                    m_req_mi = 0;
                end
            end else begin
                if (m_npend) begin
                    m_req_nmi = 1;
                end else begin
                    found = 0;
                    for (int i = 0; i < 4; i++) begin
                        if (!found && m_pend[i] && m_mask[i]) begin
                            found = 1; m_id = i;
                        end
                    end
                    if (found) m_req_mi = 1;
                end
            end
        end
        if (err_now) m_err = 1;
        for (int i = 0; i < 4; i++) begin
            if (i == clr) m_pend[i] = 0;
            if (e[i]) m_pend[i] = 1;
            m_mask[i]     = new_mask[i];
            m_prev_src[i] = irq_src[i];
        end
        if (en) m_npend = 1;
        m_prev_nmi = nmi_src;
    endtask

    // Inputs are already applied; predict the post-edge outputs, queue them, then cross the edge.
    task automatic tick();
        exp_t x;
        model_step();
        x.intr  = m_req_mi;
        x.nmint = m_req_nmi;
        x.busy  = (m_serving != 0);
        x.id    = 2'(m_id);
        x.pend  = pack4(m_pend);
        x.mask  = pack4(m_mask);
        x.err   = m_err;
        exp_q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("interrupt", 32'(interrupt), 32'(mon_e.intr));
            check("nmint",     32'(nmint),     32'(mon_e.nmint));
            check("busy",      32'(busy),      32'(mon_e.busy));
            check("irq_id",    32'(irq_id),    32'(mon_e.id));
            check("pending",   32'(pending),   32'(mon_e.pend));
            check("mask",      32'(mask),      32'(mon_e.mask));
            check("err",       32'(err),       32'(mon_e.err));
        end
    end

    task automatic serve_mi();
        int_ack = 1; ack_is_mi = 1; tick();
        int_ack = 0; eoi = 1; tick();
        eoi = 0;
    endtask

    initial begin
        // Scenario 1: single edge, 2-cycle latency, accept, return.
        rst = 1; tick(); tick();
        check("reset_err", 32'(err), 0);
        check("reset_mask", 32'(mask), 32'hF);
        check("reset_busy", 32'(busy), 0);
        rst = 0; tick();
        irq_src = 4'b0100; tick();
        check("t1_pending_E0", 32'(pending), 32'h4);
        check("t1_int_E0", 32'(interrupt), 0);
        tick();
        check("t1_int_E1", 32'(interrupt), 1);
        check("t1_id", 32'(irq_id), 2);
        int_ack = 1; ack_is_mi = 1; tick();
        check("t1_busy", 32'(busy), 1);
        check("t1_pend_clr", 32'(pending), 0);
        int_ack = 0; eoi = 1; tick();
        eoi = 0; tick();
        check("t1_after_eoi_busy", 32'(busy), 0);
        check("t1_after_eoi_int", 32'(interrupt), 0);

        // Scenario 2: simultaneous edges served lowest first.
        irq_src = 4'b0000; tick();
        irq_src = 4'b1010; tick(); tick();
        check("t2_id_first", 32'(irq_id), 1);
        int_ack = 1; ack_is_mi = 1; tick();
        int_ack = 0; eoi = 1; tick();
        eoi = 0;
        check("t2_idle_gap", 32'(interrupt), 0);
        tick();
        check("t2_second_int", 32'(interrupt), 1);
        check("t2_id_second", 32'(irq_id), 3);
        serve_mi();

        // Scenario 3: NMI preempts an unaccepted maskable request.
        irq_src = 4'b0000; tick();
        irq_src = 4'b0001; tick(); tick();
        nmi_src = 1; tick(); tick();
        check("t3_int_dropped", 32'(interrupt), 0);
        check("t3_nmint", 32'(nmint), 1);
        check("t3_pend_kept", 32'(pending), 32'h1);
        int_ack = 1; ack_is_mi = 0; tick();
        int_ack = 0; eoi = 1; tick();
        eoi = 0; tick();
        check("t3_rerequest", 32'(interrupt), 1);
        check("t3_rerequest_id", 32'(irq_id), 0);
        serve_mi();
        nmi_src = 0;

        // Scenario 4: masked source stays pending; unmask releases it.
        irq_src = 4'b0000; mask_wr = 1; mask_wdata = 4'b1110; tick();
        mask_wr = 0; irq_src = 4'b0001; tick(); tick(); tick();
        check("t4_pend_masked", 32'(pending), 32'h1);
        check("t4_no_int", 32'(interrupt), 0);
        mask_wr = 1; mask_wdata = 4'b1111; tick();
        mask_wr = 0; tick();
        check("t4_unmask_int", 32'(interrupt), 1);
        check("t4_unmask_id", 32'(irq_id), 0);
        serve_mi();

        // Scenario 5: protocol errors are sticky until reset.
        int_ack = 1; ack_is_mi = 1; tick();
        int_ack = 0; tick();
        check("t5_err_idle_ack", 32'(err), 1);
        check("t5_state_idle", 32'(busy), 0);
        nmi_src = 1; tick(); tick();
        int_ack = 1; ack_is_mi = 1; tick();
        int_ack = 0;
        check("t5_nmint_held", 32'(nmint), 1);
        rst = 1; tick();
        check("t5_rst_err", 32'(err), 0);
        check("t5_rst_mask", 32'(mask), 32'hF);
        rst = 0; nmi_src = 0; tick();

        // Scenario 6: level high through reset is not an edge; reset aborts service.
        irq_src = 4'b0010; rst = 1; tick();
        rst = 0; tick(); tick();
        check("t6_no_req", 32'(interrupt), 0);
        check("t6_no_pend", 32'(pending), 0);
        irq_src = 4'b0011; tick(); tick();
        int_ack = 1; ack_is_mi = 1; tick();
        int_ack = 0;
        check("t6_busy", 32'(busy), 1);
        rst = 1; tick();
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_pend", 32'(pending), 0);
        rst = 0;

        // Random traffic, mostly protocol-correct with occasional violations.
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 299) == 0);
            mask_wr = ($urandom_range(0, 15) == 0);
            mask_wdata = 4'($urandom);
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) irq_src[b] = ~irq_src[b];
            if ($urandom_range(0, 39) == 0) nmi_src = ~nmi_src;
            if (m_req_mi || m_req_nmi) begin
                int_ack   = ($urandom_range(0, 3) == 0);
                ack_is_mi = ($urandom_range(0, 9) == 0) ? m_req_nmi : m_req_mi;
            end else begin
                int_ack   = ($urandom_range(0, 99) == 0);
                ack_is_mi = 1'($urandom);
            end
            eoi = (m_serving != 0) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 0; int_ack = 0; eoi = 0; mask_wr = 0;
        tick(); tick();

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Requester side of the CPU interrupt handshake. The multi-cycle control unit is the acceptor.
- Collects edge-triggered requests from N maskable device lines and one non-maskable line, then latches them as pending.
- Picks one request by fixed priority and drives `interrupt`/`nmint` to the control unit.
- Takes the acceptance pulse (`savePC` with `INA`) and an end-of-interrupt strobe, and drives `busy` to block maskable requests while a handler runs.

Parameters:
- N_SRC, 4, number of maskable request lines.
- IDW, 2, width of irq_id; must satisfy 2^IDW >= N_SRC.
- MASK_RST, 4'b1111, reset value of the enable mask (1 = enabled).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- irq_src  in  N_SRC  maskable device request levels; a rising edge requests.
- nmi_src  in  1  non-maskable request level; a rising edge requests.
- mask_wr  in  1  write strobe for the mask register.
- mask_wdata  in  N_SRC  new mask value.
- int_ack  in  1  acceptance pulse from the control unit (its savePC).
- ack_is_mi  in  1  accepted type, qualified by int_ack (the control unit's INA): 1 = maskable, 0 = NMI.
- eoi  in  1  one-cycle end-of-interrupt strobe (handler return detected).
- interrupt  out  1  maskable request to the CPU.
- nmint  out  1  non-maskable request to the CPU.
- busy  out  1  handler in service; the CPU must not accept maskable requests.
- irq_id  out  IDW  index of the requested or in-service maskable source.
- pending  out  N_SRC  raw pending bits, unmasked.
- mask  out  N_SRC  current mask register.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; pending=0; nmi_pend=0; mask=MASK_RST.
  - interrupt=0, nmint=0, busy=0, irq_id=0, err=0.
  - Edge registers load the current irq_src and nmi_src, so lines already high at reset release produce no request.
  - Reset mid-request or mid-service drops everything; no replay.
- Edge detect and pending:
  - Edge e = irq_src & ~src_q, computed from the current input and src_q; src_q <= irq_src every cycle.
  - pending[i] sets on e[i] at the same edge.
  - pending[i] clears only when that source is acknowledged. If a set and a clear of the same bit fall in one cycle, the set wins.
  - nmi_pend follows the same rules on nmi_src.
- Selection:
  - eligible = pending & mask.
  - irq_id takes the lowest set index of eligible, and is latched on entering REQ_MI.
- Output timing: all outputs are registered. A source edge sampled at clock edge E0 sets pending at E0; interrupt or nmint is high after E1, i.e. 2-cycle latency.
- FSM (interrupt = state REQ_MI; nmint = state REQ_NMI; busy = state SVC_MI or SVC_NMI):
  - IDLE:
    - nmi_pend -> REQ_NMI.
    - else eligible != 0 -> REQ_MI, latch irq_id.
    - else stay.
  - REQ_MI:
    - int_ack & ack_is_mi -> SVC_MI; clear pending[irq_id].
    - else nmi_pend -> REQ_NMI (NMI preempts an unaccepted maskable request; the pending bit is kept).
    - else mask[irq_id]=0, including a mask written this cycle -> IDLE. A same-cycle ack wins over the mask write.
    - else stay.
  - REQ_NMI:
    - int_ack & ~ack_is_mi -> SVC_NMI; clear nmi_pend.
    - else stay. NMI is never withdrawn.
  - SVC_MI / SVC_NMI:
    - eoi -> IDLE.
    - New requests accumulate in pending; there is no nesting.
    - After eoi there is at least one IDLE cycle before the next request is raised.
- Protocol errors (set err; state unchanged; err cleared only by rst):
  - int_ack in IDLE, SVC_MI or SVC_NMI.
  - int_ack with a mismatched ack_is_mi.
  - eoi outside the SVC states.
- Mask:
  - mask_wr loads mask_wdata at the clock edge, in any state.
  - Masking does not clear pending; unmasking a pending bit makes it eligible in the next IDLE evaluation.

Test Plan:
1. After reset, irq_src goes 0000->0100 at E0 -> pending=0100 after E0; interrupt=1 and irq_id=2 after E1. Then int_ack=1, ack_is_mi=1 -> busy=1, pending=0000. Then eoi -> busy=0, interrupt stays 0.
2. irq_src 0000->1010 in one cycle -> irq_id=1 served first. After eoi plus one IDLE cycle, a second request with irq_id=3.
3. Maskable request raised (REQ_MI, id 0), then nmi_src edge before any ack -> interrupt=0, nmint=1. Ack with ack_is_mi=0 -> SVC_NMI. eoi -> id 0 is re-requested (pending[0] was retained).
4. mask=1110 with an edge on irq_src[0] -> pending=0001 and interrupt stays 0. Write mask=1111 -> interrupt=1, irq_id=0 two cycles later.
5. int_ack in IDLE, and int_ack with ack_is_mi=1 during REQ_NMI -> err=1, state unchanged. Then rst -> err=0 and mask=1111.
6. irq_src[1] held high across reset release -> no request. Assert rst during SVC_MI -> busy=0 next cycle and pending=0.
